// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the pifan command decoder: register map, FSM states,
// CTRL bit positions and register reset values.
package fan_ctrl_pkg;

  localparam logic [3:0] ADDR_ID    = 4'h0;
  localparam logic [3:0] ADDR_DUTY0 = 4'h1;
  localparam logic [3:0] ADDR_DUTY1 = 4'h2;
  localparam logic [3:0] ADDR_CTRL  = 4'h3;
  localparam logic [3:0] ADDR_TACH0 = 4'h4;
  localparam logic [3:0] ADDR_TACH1 = 4'h5;

  localparam int CTRL_EN0 = 0;
  localparam int CTRL_EN1 = 1;

  localparam logic [7:0] DUTY_RST  = 8'h80;
  localparam logic [7:0] CTRL_RST  = 8'h03;
  localparam logic [7:0] CTRL_MASK = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RRESP = 2'd2
  } state_e;

endpackage

// File: rtl/fan_spi_regs_if.sv
// Byte-level handshake between the SPI slave core and the fan register block.
interface fan_spi_regs_if;
  logic       iRxReady;
  logic [7:0] iRx;
  logic       iSPICS;
  logic       oTxReady;
  logic [7:0] oTx;

  modport master (output iRxReady, iRx, iSPICS, input oTxReady, oTx);
  modport slave  (input iRxReady, iRx, iSPICS, output oTxReady, oTx);
endinterface

// File: rtl/fan_spi_regs_pwm_tach.sv
// One fan channel: prescaled 0..254 PWM with duty shadowed to the counter wrap,
// plus a synchronised tach edge counter latched on the shared window strobe.
module fan_pwm_tach
  import fan_ctrl_pkg::*;
#(
  parameter int PWM_DIV = 4
) (
  input  logic       sysclk,
  input  logic       iRstN,
  input  logic       en_i,
  input  logic [7:0] duty_i,
  input  logic       tach_i,
  input  logic       gate_i,
  output logic       pwm_o,
  output logic [7:0] tach_o
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             pwm_q, pwm_d;
  logic [1:0]       tsync_q;
  logic             tprev_q;
  logic [7:0]       edges_q, edges_d;
  logic [7:0]       tach_q, tach_d;
  logic             step, rise;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  assign step = (pre_q == PRE_W'(PWM_DIV - 1));
  assign rise = tsync_q[1] & ~tprev_q;

  always_comb begin
    pre_d    = step ? '0 : pre_q + 1'b1;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (step) begin
      if (cnt_q == 8'd254) begin
        cnt_d    = 8'd0;
        shadow_d = duty_i;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    pwm_d = en_i & (cnt_q < shadow_q);
    // An edge coinciding with the window end still belongs to the closing window.
    if (gate_i) begin
      tach_d  = sat_inc(edges_q, rise);
      edges_d = 8'd0;
    end else begin
      tach_d  = tach_q;
      edges_d = sat_inc(edges_q, rise);
    end
  end

  always_ff @(posedge sysclk or negedge iRstN) begin
    if (!iRstN) begin
      pre_q    <= '0;
      cnt_q    <= 8'd0;
      shadow_q <= DUTY_RST;
      pwm_q    <= 1'b0;
      tsync_q  <= 2'b00;
      tprev_q  <= 1'b0;
      edges_q  <= 8'd0;
      tach_q   <= 8'd0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
      tsync_q  <= {tsync_q[0], tach_i};
      tprev_q  <= tsync_q[1];
      edges_q  <= edges_d;
      tach_q   <= tach_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign tach_o = tach_q;

endmodule

// File: rtl/fan_spi_regs.sv
// Command decoder and register file behind the SPI slave byte port: decodes
// read/write commands, drives two fan PWMs and reports two tach counts.
module fan_spi_regs
  import fan_ctrl_pkg::*;
#(
  parameter int         PWM_DIV     = 4,
  parameter int         GATE_CYCLES = 12_000_000,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic                 sysclk,
  input  logic                 iRstN,
  fan_spi_regs_if.slave        spi,
  input  logic [1:0]           iTach,
  output logic [1:0]           oPwm,
  output logic [7:0]           oProbe
);

  state_e      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  duty0_q, duty0_d, duty1_q, duty1_d, ctrl_q, ctrl_d;
  logic [7:0]  tx_q, tx_d;
  logic        txrdy_q, txrdy_d;
  logic [1:0]  rxs_q, css_q;
  logic        rxprev_q;
  logic [31:0] gate_q;
  logic        gate_end, byte_ev, cs_hi;
  logic [7:0]  tach0, tach1, rd_data;

  assign byte_ev  = rxs_q[1] & ~rxprev_q;
  assign cs_hi    = css_q[1];
  assign gate_end = (gate_q == 32'(GATE_CYCLES - 1));

  always_comb begin
    rd_data = 8'h00;
    case (spi.iRx[3:0])
      ADDR_ID:    rd_data = ID_VALUE;
      ADDR_DUTY0: rd_data = duty0_q;
      ADDR_DUTY1: rd_data = duty1_q;
      ADDR_CTRL:  rd_data = ctrl_q;
      ADDR_TACH0: rd_data = tach0;
      ADDR_TACH1: rd_data = tach1;
      default:    rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    duty0_d = duty0_q;
    duty1_d = duty1_q;
    ctrl_d  = ctrl_q;
    tx_d    = tx_q;
    txrdy_d = txrdy_q;
    // Chip-select release aborts the frame and drops any byte event in the same cycle.
    if (cs_hi) begin
      state_d = ST_IDLE;
      txrdy_d = 1'b0;
    end else if (byte_ev) begin
      case (state_q)
        ST_IDLE: begin
          addr_d = spi.iRx[3:0];
          if (spi.iRx[7]) begin
            state_d = ST_WDATA;
          end else begin
            tx_d    = rd_data;
            txrdy_d = 1'b1;
            state_d = ST_RRESP;
          end
        end
        ST_WDATA: begin
          case (addr_q)
            ADDR_DUTY0: duty0_d = spi.iRx;
            ADDR_DUTY1: duty1_d = spi.iRx;
            ADDR_CTRL:  ctrl_d  = spi.iRx & CTRL_MASK;
            default:    ;
          endcase
          state_d = ST_IDLE;
        end
        ST_RRESP: begin
          txrdy_d = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= ST_IDLE;
      addr_q   <= 4'h0;
      duty0_q  <= DUTY_RST;
      duty1_q  <= DUTY_RST;
      ctrl_q   <= CTRL_RST;
      tx_q     <= 8'h00;
      txrdy_q  <= 1'b0;
      rxs_q    <= 2'b00;
      css_q    <= 2'b00;
      rxprev_q <= 1'b0;
      gate_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      duty0_q  <= duty0_d;
      duty1_q  <= duty1_d;
      ctrl_q   <= ctrl_d;
      tx_q     <= tx_d;
      txrdy_q  <= txrdy_d;
      rxs_q    <= {rxs_q[0], spi.iRxReady};
      css_q    <= {css_q[0], spi.iSPICS};
      rxprev_q <= rxs_q[1];
      gate_q   <= gate_end ? 32'd0 : gate_q + 32'd1;
    end
  end

  fan_pwm_tach #(.PWM_DIV(PWM_DIV)) u_fan0 (
    .sysclk (sysclk),
    .iRstN  (iRstN),
    .en_i   (ctrl_q[CTRL_EN0]),
    .duty_i (duty0_q),
    .tach_i (iTach[0]),
    .gate_i (gate_end),
    .pwm_o  (oPwm[0]),
    .tach_o (tach0)
  );

  fan_pwm_tach #(.PWM_DIV(PWM_DIV)) u_fan1 (
    .sysclk (sysclk),
    .iRstN  (iRstN),
    .en_i   (ctrl_q[CTRL_EN1]),
    .duty_i (duty1_q),
    .tach_i (iTach[1]),
    .gate_i (gate_end),
    .pwm_o  (oPwm[1]),
    .tach_o (tach1)
  );

  assign spi.oTxReady = txrdy_q;
  assign spi.oTx      = tx_q;
  assign oProbe       = {state_q, 2'b00, addr_q};

endmodule

// File: tb/tb_fan_spi_regs.sv
// Directed bench for fan_spi_regs: register access, PWM duty, CS abort, tach and reset.
module tb_fan_spi_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tach0 = 1'b0, tach1 = 1'b0;
  logic [1:0] tach_w;
  logic [1:0] pwm;
  logic [7:0] probe;
  int         tper0 = 0, tper1 = 0;
  int         n_checks = 0, n_fail = 0;

  fan_spi_regs_if spi ();

  assign tach_w = {tach1, tach0};

  fan_spi_regs #(.PWM_DIV(4), .GATE_CYCLES(1000), .ID_VALUE(8'hA5)) dut (
    .sysclk (clk),
    .iRstN  (rst_n),
    .spi    (spi),
    .iTach  (tach_w),
    .oPwm   (pwm),
    .oProbe (probe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    forever begin
      if (tper0 > 0) begin
        tach0 = 1'b1; tick(tper0 / 2);
        tach0 = 1'b0; tick(tper0 - tper0 / 2);
      end else begin
        tach0 = 1'b0; tick(1);
      end
    end
  end

  initial begin
    forever begin
      if (tper1 > 0) begin
        tach1 = 1'b1; tick(tper1 / 2);
        tach1 = 1'b0; tick(tper1 - tper1 / 2);
      end else begin
        tach1 = 1'b0; tick(1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    spi.iRx = b;
    spi.iRxReady = 1'b1;
    tick(5);
    spi.iRxReady = 1'b0;
    tick(5);
  endtask

  task automatic do_read(input logic [3:0] a, output logic [7:0] d, output logic rdy1, output logic rdy2);
    send_byte({4'h0, a});
    d = spi.oTx;
    rdy1 = spi.oTxReady;
    send_byte(8'h00);
    rdy2 = spi.oTxReady;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] v);
    send_byte({4'h8, a});
    send_byte(v);
  endtask

  task automatic measure(output int h0, output int h1);
    h0 = 0; h1 = 0;
    repeat (1020) begin
      @(negedge clk);
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    spi.iRxReady = 1'b0; spi.iRx = 8'h00; spi.iSPICS = 1'b0;
    tick(3);
    n_checks++; if (spi.oTxReady !== 1'b0) begin n_fail++; $display("FAIL reset_txready got %b want 0", spi.oTxReady); end
    n_checks++; if (spi.oTx !== 8'h00) begin n_fail++; $display("FAIL reset_tx got %h want 00", spi.oTx); end
    n_checks++; if (pwm !== 2'b00) begin n_fail++; $display("FAIL reset_pwm got %b want 00", pwm); end
    n_checks++; if (probe !== 8'h00) begin n_fail++; $display("FAIL reset_probe got %h want 00", probe); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_read_id;
    send_byte(8'h00);
    n_checks++; if (spi.oTx !== 8'hA5) begin n_fail++; $display("FAIL id_data got %h want a5", spi.oTx); end
    n_checks++; if (spi.oTxReady !== 1'b1) begin n_fail++; $display("FAIL id_ready got %b want 1", spi.oTxReady); end
    n_checks++; if (probe !== 8'h80) begin n_fail++; $display("FAIL id_probe_rresp got %h want 80", probe); end
    send_byte(8'h00);
    n_checks++; if (spi.oTxReady !== 1'b0) begin n_fail++; $display("FAIL id_ready_after got %b want 0", spi.oTxReady); end
    n_checks++; if (probe !== 8'h00) begin n_fail++; $display("FAIL id_probe_idle got %h want 00", probe); end
  endtask

  task automatic test_reset_regs;
    logic [7:0] d; logic r1, r2;
    do_read(4'h1, d, r1, r2);
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL rst_duty0 got %h want 80", d); end
    do_read(4'h2, d, r1, r2);
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL rst_duty1 got %h want 80", d); end
    do_read(4'h3, d, r1, r2);
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL rst_ctrl got %h want 03", d); end
    do_read(4'h4, d, r1, r2);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_tach0 got %h want 00", d); end
    do_read(4'h7, d, r1, r2);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_read got %h want 00", d); end
  endtask

  task automatic test_cs_abort;
    logic [7:0] d; logic r1, r2;
    send_byte(8'h81);
    n_checks++; if (probe !== 8'h41) begin n_fail++; $display("FAIL abort_probe_wdata got %h want 41", probe); end
    spi.iSPICS = 1'b1; tick(4);
    n_checks++; if (probe[7:6] !== 2'b00) begin n_fail++; $display("FAIL abort_state got %b want 00", probe[7:6]); end
    spi.iSPICS = 1'b0; tick(4);
    do_read(4'h1, d, r1, r2);
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL abort_duty0 got %h want 80", d); end
    send_byte(8'h03);
    n_checks++; if (spi.oTxReady !== 1'b1) begin n_fail++; $display("FAIL abort_rresp_ready got %b want 1", spi.oTxReady); end
    spi.iSPICS = 1'b1; tick(4);
    n_checks++; if (spi.oTxReady !== 1'b0) begin n_fail++; $display("FAIL abort_rresp_cleared got %b want 0", spi.oTxReady); end
    spi.iSPICS = 1'b0; tick(4);
    do_read(4'h3, d, r1, r2);
    n_checks++; if (d !== 8'h03 || r1 !== 1'b1 || r2 !== 1'b0) begin n_fail++; $display("FAIL abort_recover got %h/%b/%b want 03/1/0", d, r1, r2); end
  endtask

  task automatic test_write_duty;
    logic [7:0] d; logic r1, r2; int h0, h1;
    do_write(4'h1, 8'h40);
    do_read(4'h1, d, r1, r2);
    n_checks++; if (d !== 8'h40) begin n_fail++; $display("FAIL duty0_readback got %h want 40", d); end
    tick(1100);
    measure(h0, h1);
    n_checks++; if (h0 !== 256) begin n_fail++; $display("FAIL pwm0_duty40 got %0d want 256", h0); end
    n_checks++; if (h1 !== 512) begin n_fail++; $display("FAIL pwm1_duty80 got %0d want 512", h1); end
  endtask

  task automatic test_ctrl;
    logic [7:0] d; logic r1, r2; int h0, h1;
    do_write(4'h3, 8'h02);
    do_read(4'h3, d, r1, r2);
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL ctrl_readback got %h want 02", d); end
    measure(h0, h1);
    n_checks++; if (h0 !== 0) begin n_fail++; $display("FAIL pwm0_disabled got %0d want 0", h0); end
    n_checks++; if (h1 !== 512) begin n_fail++; $display("FAIL pwm1_enabled got %0d want 512", h1); end
    do_write(4'h3, 8'hFF);
    do_read(4'h3, d, r1, r2);
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL ctrl_mask got %h want 03", d); end
  endtask

  task automatic test_duty_bounds;
    int h0, h1;
    do_write(4'h1, 8'h00);
    do_write(4'h2, 8'hFF);
    tick(1100);
    measure(h0, h1);
    n_checks++; if (h0 !== 0) begin n_fail++; $display("FAIL pwm0_duty00 got %0d want 0", h0); end
    n_checks++; if (h1 !== 1020) begin n_fail++; $display("FAIL pwm1_dutyff got %0d want 1020", h1); end
  endtask

  task automatic test_ro_ignored;
    logic [7:0] d; logic r1, r2;
    do_write(4'h0, 8'h12);
    do_read(4'h0, d, r1, r2);
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL id_write_ignored got %h want a5", d); end
    do_write(4'h4, 8'h55);
    do_read(4'h4, d, r1, r2);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL tach0_write_ignored got %h want 00", d); end
    do_write(4'h9, 8'h77);
    do_read(4'h9, d, r1, r2);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_write got %h want 00", d); end
  endtask

  task automatic test_tach;
    logic [7:0] d; logic r1, r2;
    tper0 = 100; tper1 = 3;
    tick(2200);
    do_read(4'h4, d, r1, r2);
    n_checks++; if (d !== 8'd10) begin n_fail++; $display("FAIL tach0_10 got %0d want 10", d); end
    do_read(4'h5, d, r1, r2);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL tach1_sat got %h want ff", d); end
    tper0 = 3; tper1 = 0;
    tick(2200);
    do_read(4'h4, d, r1, r2);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL tach0_sat got %h want ff", d); end
    do_read(4'h5, d, r1, r2);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL tach1_idle got %h want 00", d); end
    tper0 = 0;
    tick(2200);
    do_read(4'h4, d, r1, r2);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL tach0_cleared got %h want 00", d); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d; logic r1, r2;
    do_write(4'h1, 8'h33);
    send_byte(8'h81);
    n_checks++; if (probe !== 8'h41) begin n_fail++; $display("FAIL mid_probe_wdata got %h want 41", probe); end
    spi.iRx = 8'h55; spi.iRxReady = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(2);
    n_checks++; if (probe !== 8'h00) begin n_fail++; $display("FAIL mid_probe_reset got %h want 00", probe); end
    n_checks++; if (spi.oTxReady !== 1'b0) begin n_fail++; $display("FAIL mid_txready got %b want 0", spi.oTxReady); end
    n_checks++; if (pwm !== 2'b00) begin n_fail++; $display("FAIL mid_pwm got %b want 00", pwm); end
    spi.iRxReady = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    do_read(4'h1, d, r1, r2);
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL mid_duty0 got %h want 80", d); end
    do_read(4'h2, d, r1, r2);
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL mid_duty1 got %h want 80", d); end
    do_read(4'h3, d, r1, r2);
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL mid_ctrl got %h want 03", d); end
    do_read(4'h7, d, r1, r2);
    n_checks++; if (d !== 8'h00 || r2 !== 1'b0) begin n_fail++; $display("FAIL mid_read7 got %h/%b want 00/0", d, r2); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_reset_regs();
    test_cs_abort();
    test_write_duty();
    test_ctrl();
    test_duty_bounds();
    test_ro_ignored();
    test_tach();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
